// File: rtl/corescore_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one byte-stream sink between N stream sources.
// Optional idle watchdog inside a packet: define STREAM_ARB_WATCHDOG_EN.
module corescore_stream_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [N*W-1:0] i_tdata,
  input  logic [N-1:0]   i_tlast,
  input  logic [N-1:0]   i_tvalid,
  output logic [N-1:0]   o_tready,
  output logic [W-1:0]   o_tdata,
  output logic           o_tlast,
  output logic           o_tvalid,
  input  logic           i_tready,
  output logic [N-1:0]   o_grant,
  output logic           o_timeout
);

  // Handshake: a beat moves when valid and ready are both high at a rising edge; a source
  // holds tvalid and tdata stable until accepted, and ready may depend combinationally on valid.

  localparam int IDX_W = $clog2(N);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, pick;
  logic [N-1:0]     grant_q, grant_d;
  logic             any_req;
  logic             beat_last;
  logic             wd_fire;
  logic [W-1:0]     src_data [N];

  // The pointer holds the current owner while BUSY, so it doubles as the mux select.
  always_comb begin : p_pick
    logic [IDX_W-1:0] idx;
    idx     = '0;
    pick    = ptr_q;
    any_req = |i_tvalid;
    for (int k = N; k >= 1; k--) begin
      idx = IDX_W'((int'(ptr_q) + k) % N);
      if (i_tvalid[idx]) pick = idx;
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) src_data[k] = i_tdata[k*W +: W];
  end

  always_comb begin
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    o_tready = '0;
    if (state_q == BUSY) begin
      o_tdata         = src_data[ptr_q];
      o_tlast         = i_tlast[ptr_q];
      o_tvalid        = i_tvalid[ptr_q];
      o_tready[ptr_q] = i_tready;
    end
  end

  assign beat_last = o_tvalid & i_tready & o_tlast;

`ifdef STREAM_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt_q;
  logic             timeout_q;

  // Fires on the edge that would bring the stall count up to TIMEOUT.
  assign wd_fire = (state_q == BUSY) && !o_tvalid && (idle_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
      if (state_q != BUSY || o_tvalid || wd_fire) idle_cnt_q <= '0;
      else                                        idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign wd_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = BUSY;
          ptr_d         = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      BUSY: begin
        if (beat_last || wd_fire) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign o_grant = grant_q;

endmodule
